// File: rtl/softmax_accumulator_pkg.sv
// Shared types and constants for the softmax denominator accumulator.
package softmax_accumulator_pkg;

   localparam int FP_W = 32;
   localparam logic [FP_W-1:0] FP_ZERO = 32'h00000000;

   typedef enum logic [1:0] {
      GET_IN  = 2'd0,
      SEND_AB = 2'd1,
      WAIT_Z  = 2'd2,
      PUT_SUM = 2'd3
   } state_t;

endpackage

// File: rtl/softmax_accumulator.sv
// Sums a vector of floats through an external handshaked adder, one add at a time,
// and presents the total and element count as the softmax denominator.
module softmax_accumulator
   import softmax_accumulator_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [FP_W-1:0]  in_data,
   input  logic             in_last,
   input  logic             in_stb,
   output logic             in_ack,
   output logic [FP_W-1:0]  add_a,
   output logic [FP_W-1:0]  add_b,
   output logic             add_a_stb,
   output logic             add_b_stb,
   input  logic             add_a_ack,
   input  logic             add_b_ack,
   input  logic [FP_W-1:0]  add_z,
   input  logic             add_z_stb,
   output logic             add_z_ack,
   output logic [FP_W-1:0]  sum,
   output logic [CNT_W-1:0] count,
   output logic             sum_stb,
   input  logic             sum_ack
);

   state_t           r_state;
   state_t           w_stateNext;
   logic [FP_W-1:0]  r_acc;
   logic [FP_W-1:0]  r_elem;
   logic             r_last;
   logic             r_aStb;
   logic             r_bStb;
   logic [CNT_W-1:0] r_count;
   logic             w_aDone;
   logic             w_bDone;

   // An operand counts as delivered once its strobe has dropped or is being acked now.
   assign w_aDone = ~r_aStb | add_a_ack;
   assign w_bDone = ~r_bStb | add_b_ack;

   assign add_a     = r_acc;
   assign add_b     = r_elem;
   assign add_a_stb = r_aStb;
   assign add_b_stb = r_bStb;
   assign sum       = r_acc;
   assign count     = r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= GET_IN;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      in_ack      = 1'b0;
      add_z_ack   = 1'b0;
      sum_stb     = 1'b0;
      case (r_state)
         GET_IN: begin
            in_ack = ~rst;
            if (in_stb && !rst) begin
               w_stateNext = SEND_AB;
            end
         end
         SEND_AB: begin
            if (w_aDone && w_bDone) begin
               w_stateNext = WAIT_Z;
            end
         end
         WAIT_Z: begin
            add_z_ack = 1'b1;
            if (add_z_stb) begin
               w_stateNext = r_last ? PUT_SUM : GET_IN;
            end
         end
         PUT_SUM: begin
            sum_stb = 1'b1;
            if (sum_ack) begin
               w_stateNext = GET_IN;
            end
         end
         default: w_stateNext = GET_IN;
      endcase
   end

   // Each operand strobe is cleared by its own ack, so a and b may be accepted on different cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc   <= FP_ZERO;
         r_elem  <= FP_ZERO;
         r_last  <= 1'b0;
         r_aStb  <= 1'b0;
         r_bStb  <= 1'b0;
         r_count <= '0;
      end else begin
         case (r_state)
            GET_IN: begin
               if (in_stb) begin
                  r_elem <= in_data;
                  r_last <= in_last;
                  r_aStb <= 1'b1;
                  r_bStb <= 1'b1;
               end
            end
            SEND_AB: begin
               if (add_a_ack) begin
                  r_aStb <= 1'b0;
               end
               if (add_b_ack) begin
                  r_bStb <= 1'b0;
               end
            end
            WAIT_Z: begin
               if (add_z_stb) begin
                  r_acc <= add_z;
                  if (r_count != {CNT_W{1'b1}}) begin
                     r_count <= r_count + CNT_W'(1);
                  end
               end
            end
            PUT_SUM: begin
               if (sum_ack) begin
                  r_acc   <= FP_ZERO;
                  r_count <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_softmax_accumulator.sv
// Scoreboard bench for softmax_accumulator with a behavioural handshaked adder model.
module tb_softmax_accumulator;

   logic        clk;
   logic        rst;
   logic [31:0] in_data;
   logic        in_last;
   logic        in_stb;
   logic        in_ack;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic        add_a_stb;
   logic        add_b_stb;
   logic        add_a_ack;
   logic        add_b_ack;
   logic [31:0] add_z;
   logic        add_z_stb;
   logic        add_z_ack;
   logic [31:0] sum;
   logic [15:0] count;
   logic        sum_stb;
   logic        sum_ack;

   typedef struct {
      logic [31:0] sum;
      logic [15:0] cnt;
   } exp_t;

   exp_t expQ[$];
   int   checkCount  = 0;
   int   passCount   = 0;
   int   aDelay      = 0;
   int   bDelay      = 0;
   int   zDelay      = 0;
   int   stallCycles = 0;
   bit   monitorBusy = 0;

   softmax_accumulator #(.CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_stb    (in_stb),
      .in_ack    (in_ack),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_a_stb (add_a_stb),
      .add_b_stb (add_b_stb),
      .add_a_ack (add_a_ack),
      .add_b_ack (add_b_ack),
      .add_z     (add_z),
      .add_z_stb (add_z_stb),
      .add_z_ack (add_z_ack),
      .sum       (sum),
      .count     (count),
      .sum_stb   (sum_stb),
      .sum_ack   (sum_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-computed float sums for every operand pair the vectors produce.
   function automatic logic [31:0] fpAdd(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h00000000, 32'h3f800000}: return 32'h3f800000;
         {32'h00000000, 32'h3f000000}: return 32'h3f000000;
         {32'h3f000000, 32'h3f000000}: return 32'h3f800000;
         {32'h3f000000, 32'hbf000000}: return 32'h00000000;
         {32'h3f800000, 32'h3f800000}: return 32'h40000000;
         default:                      return 32'h7fc00bad;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic reportTimeout(input string name);
      checkCount++;
      $display("[TB] FAIL %s: got no handshake, expected one within the cycle budget", name);
   endtask

   task automatic checkResetOutputs(input string name, input logic inAckExp);
      checkOutput({name, "Strobes"}, {27'b0, in_ack, add_a_stb, add_b_stb, add_z_ack, sum_stb},
                  {27'b0, inAckExp, 4'b0});
      checkOutput({name, "Sum"}, sum, 32'h0);
      checkOutput({name, "Count"}, {16'b0, count}, 32'h0);
      checkOutput({name, "Operands"}, add_a | add_b, 32'h0);
   endtask

   task automatic sendElem(input logic [31:0] d, input logic l);
      int n;
      @(negedge clk);
      in_data = d;
      in_last = l;
      in_stb  = 1'b1;
      n = 0;
      while (!in_ack && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ack) begin
         reportTimeout("inAck");
      end else begin
         @(posedge clk);
         #1;
      end
      in_stb = 1'b0;
   endtask

   task automatic applyStimulus(input logic [31:0] e0, input logic [31:0] e1, input int nElem,
                                input logic [31:0] expSum, input int expCnt);
      exp_t e;
      e.sum = expSum;
      e.cnt = 16'(expCnt);
      expQ.push_back(e);
      sendElem(e0, nElem == 1);
      if (nElem == 2) begin
         sendElem(e1, 1'b1);
      end
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while ((expQ.size() != 0 || monitorBusy) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (expQ.size() != 0 || monitorBusy) begin
         reportTimeout("sumIdle");
      end
      repeat (2) @(negedge clk);
   endtask

   // Adder model: acks operands after configurable delays, then returns the table sum.
   initial begin : adderModel
      logic [31:0] opA;
      logic [31:0] opB;
      bit          aDone;
      bit          bDone;
      bit          aborted;
      int          cyc;
      add_a_ack = 1'b0;
      add_b_ack = 1'b0;
      add_z_stb = 1'b0;
      add_z     = 32'h0;
      forever begin
         @(negedge clk);
         if (!rst && add_a_stb && add_b_stb) begin
            opA = add_a;
            opB = add_b;
            aDone = 0;
            bDone = 0;
            aborted = 0;
            cyc = 0;
            while (!(aDone && bDone) && !aborted) begin
               add_a_ack = !aDone && (cyc >= aDelay);
               add_b_ack = !bDone && (cyc >= bDelay);
               @(posedge clk);
               if (add_a_ack) aDone = 1;
               if (add_b_ack) bDone = 1;
               #1;
               add_a_ack = 1'b0;
               add_b_ack = 1'b0;
               if (!(aDone && bDone)) begin
                  @(negedge clk);
                  cyc++;
                  if (rst) begin
                     aborted = 1;
                  end else if (aDone) begin
                     checkOutput("stbSkewA", {30'b0, add_a_stb, add_b_stb}, 32'h1);
                  end else if (bDone) begin
                     checkOutput("stbSkewB", {30'b0, add_a_stb, add_b_stb}, 32'h2);
                  end
                  if (cyc > 50) begin
                     reportTimeout("operandAck");
                     aborted = 1;
                  end
               end
            end
            for (int k = 0; k <= zDelay && !aborted; k++) begin
               @(negedge clk);
               if (rst) aborted = 1;
            end
            if (!aborted) begin
               add_z     = fpAdd(opA, opB);
               add_z_stb = 1'b1;
               cyc = 0;
               while (!add_z_ack && !rst && cyc < 50) begin
                  @(negedge clk);
                  cyc++;
               end
               if (!rst) begin
                  if (!add_z_ack) begin
                     reportTimeout("zAck");
                  end else begin
                     @(posedge clk);
                     #1;
                  end
               end
               add_z_stb = 1'b0;
            end
         end
      end
   end

   // Sum sink and scoreboard monitor: compares each presented sum, optionally stalls the ack.
   initial begin : sumMonitor
      exp_t e;
      sum_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (sum_stb && !rst) begin
            monitorBusy = 1;
            if (expQ.size() == 0) begin
               checkCount++;
               $display("[TB] FAIL unexpectedSum: got sum %h with no expected entry, expected none", sum);
               e.sum = sum;
               e.cnt = count;
            end else begin
               e = expQ.pop_front();
               checkOutput("sum", sum, e.sum);
               checkOutput("count", {16'b0, count}, {16'b0, e.cnt});
            end
            for (int k = 0; k < stallCycles; k++) begin
               @(negedge clk);
               checkOutput("stallSum", sum, e.sum);
               checkOutput("stallCount", {16'b0, count}, {16'b0, e.cnt});
               checkOutput("stallFlags", {30'b0, sum_stb, in_ack}, 32'h2);
            end
            sum_ack = 1'b1;
            @(posedge clk);
            #1;
            sum_ack = 1'b0;
            @(negedge clk);
            checkOutput("postAckFlags", {30'b0, sum_stb, in_ack}, 32'h1);
            checkOutput("postAckAcc", sum, 32'h0);
            monitorBusy = 0;
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
      $display("%0d/%0d checks passed", passCount, checkCount + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : mainStim
      int n;
      rst     = 1'b1;
      in_data = 32'h0;
      in_last = 1'b0;
      in_stb  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetOutputs("inReset", 1'b0);
      rst = 1'b0;
      #1;
      checkResetOutputs("afterReset", 1'b1);

      applyStimulus(32'h3f800000, 32'h0, 1, 32'h3f800000, 1);
      applyStimulus(32'h3f000000, 32'h3f000000, 2, 32'h3f800000, 2);
      applyStimulus(32'h3f000000, 32'hbf000000, 2, 32'h00000000, 2);
      waitIdle();

      aDelay = 0;
      bDelay = 3;
      applyStimulus(32'h3f800000, 32'h3f800000, 2, 32'h40000000, 2);
      waitIdle();
      aDelay = 2;
      bDelay = 0;
      applyStimulus(32'h3f000000, 32'h3f000000, 2, 32'h3f800000, 2);
      waitIdle();
      aDelay = 0;
      bDelay = 0;

      stallCycles = 5;
      applyStimulus(32'h3f800000, 32'h0, 1, 32'h3f800000, 1);
      waitIdle();
      stallCycles = 0;
      applyStimulus(32'h3f000000, 32'h3f000000, 2, 32'h3f800000, 2);
      waitIdle();

      zDelay = 5;
      sendElem(32'h3f800000, 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!add_z_ack && n < 50);
      if (!add_z_ack) begin
         reportTimeout("reachWaitZ");
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkResetOutputs("midReset", 1'b0);
      rst = 1'b0;
      #1;
      checkResetOutputs("midResetRelease", 1'b1);
      zDelay = 0;
      applyStimulus(32'h3f800000, 32'h0, 1, 32'h3f800000, 1);
      waitIdle();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
